// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Fetch stage: PC register, next-PC select, IF/ID register, stall/flush counters
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             BranchTakenE,
  input  logic [31:0]      ALUResultE,
  input  logic             PCSrcW,
  input  logic [31:0]      ResultW,
  input  logic [31:0]      InstrF,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus8D,
  output logic             ValidD,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  logic [31:0] pcplus4f;
  logic [31:0] pcnext;
  logic        redirect;

  assign pcplus4f = PCF + 32'd4;
  assign redirect = BranchTakenE | PCSrcW;

  always_comb begin
    pcnext = pcplus4f;
    if (BranchTakenE)
      pcnext = ALUResultE;
    else if (PCSrcW)
      pcnext = ResultW;
  end

  // A redirect must land even while fetch is stalled, otherwise the target would be lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      PCF <= RESET_PC;
    else if (redirect || !StallF)
      PCF <= pcnext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD   <= NOP_INSTR;
      PCPlus8D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCPlus8D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCPlus8D <= pcplus4f + 32'd4;
      ValidD   <= 1'b1;
    end
  end

  // Saturating event counters; a flushed cycle never counts as a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD && !FlushD && (StallCnt != {CNT_W{1'b1}}))
        StallCnt <= StallCnt + CNT_W'(1);
      if (FlushD && (FlushCnt != {CNT_W{1'b1}}))
        FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - Directed self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, BranchTakenE, PCSrcW;
  logic [31:0] ALUResultE, ResultW;
  logic [31:0] instr_f, instr_f4;
  logic [31:0] pcf, instr_d, pcplus8_d;
  logic        valid_d;
  logic [15:0] stall_cnt, flush_cnt;
  logic [31:0] pcf4, instr_d4, pcplus8_d4;
  logic        valid_d4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word at address a is a ^ KEY.
  assign instr_f  = pcf ^ KEY;
  assign instr_f4 = pcf4 ^ KEY;

  fetch_stage dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW), .ResultW(ResultW),
    .InstrF(instr_f), .PCF(pcf), .InstrD(instr_d), .PCPlus8D(pcplus8_d), .ValidD(valid_d),
    .StallCnt(stall_cnt), .FlushCnt(flush_cnt)
  );

  fetch_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW), .ResultW(ResultW),
    .InstrF(instr_f4), .PCF(pcf4), .InstrD(instr_d4), .PCPlus8D(pcplus8_d4), .ValidD(valid_d4),
    .StallCnt(stall_cnt4), .FlushCnt(flush_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    StallF = 0; StallD = 0; FlushD = 0; BranchTakenE = 0; PCSrcW = 0;
    ALUResultE = 0; ResultW = 0;
  endtask

  task automatic pulse_reset();
    reset = 1;
    #1;
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    #2;
    check("rst_pcf", pcf, 32'h0);
    check("rst_instrd", instr_d, 32'h0);
    check("rst_pc8d", pcplus8_d, 32'h0);
    check("rst_valid", {31'b0, valid_d}, 32'h0);
    check("rst_stallcnt", {16'b0, stall_cnt}, 32'h0);
    check("rst_flushcnt", {16'b0, flush_cnt}, 32'h0);
    reset = 0;

    // 1: free run
    for (int i = 1; i <= 4; i++) begin
      step();
      check("free_pcf", pcf, 32'(4 * i));
      check("free_instrd", instr_d, 32'(4 * (i - 1)) ^ KEY);
      check("free_pc8d", pcplus8_d, 32'(4 * (i - 1) + 8));
      check("free_valid", {31'b0, valid_d}, 32'h1);
    end

    // 2: stall at PCF=8
    pulse_reset();
    step();
    step();
    check("pre_stall_pcf", pcf, 32'h8);
    StallF = 1; StallD = 1;
    step();
    step();
    check("stall_pcf", pcf, 32'h8);
    check("stall_instrd", instr_d, 32'h4 ^ KEY);
    check("stall_pc8d", pcplus8_d, 32'hC);
    check("stall_cnt", {16'b0, stall_cnt}, 32'h2);
    check("stall_flushcnt", {16'b0, flush_cnt}, 32'h0);

    // 3: branch with flush
    idle_inputs();
    BranchTakenE = 1; ALUResultE = 32'h100; FlushD = 1;
    step();
    check("br_pcf", pcf, 32'h100);
    check("br_instrd", instr_d, 32'h0);
    check("br_valid", {31'b0, valid_d}, 32'h0);
    check("br_pc8d", pcplus8_d, 32'h0);
    check("br_flushcnt", {16'b0, flush_cnt}, 32'h1);
    idle_inputs();
    step();
    check("br_tgt_instrd", instr_d, 32'hA5A5_0100);
    check("br_tgt_pc8d", pcplus8_d, 32'h108);
    check("br_tgt_valid", {31'b0, valid_d}, 32'h1);
    check("br_tgt_pcf", pcf, 32'h104);

    // 4: branch beats PC write, redirect beats StallF
    BranchTakenE = 1; ALUResultE = 32'h40; PCSrcW = 1; ResultW = 32'h80; StallF = 1;
    step();
    check("prio_pcf", pcf, 32'h40);
    check("prio_instrd", instr_d, 32'h104 ^ KEY);
    BranchTakenE = 0;
    step();
    check("pcsrcw_pcf", pcf, 32'h80);
    PCSrcW = 0;
    step();
    check("stallf_hold_pcf", pcf, 32'h80);
    check("stallf_dup_instrd", instr_d, 32'h80 ^ KEY);
    check("stallf_dup_pc8d", pcplus8_d, 32'h88);

    // 5: flush beats stall
    idle_inputs();
    FlushD = 1; StallD = 1;
    step();
    check("fs_valid", {31'b0, valid_d}, 32'h0);
    check("fs_instrd", instr_d, 32'h0);
    check("fs_stallcnt", {16'b0, stall_cnt}, 32'h2);
    check("fs_flushcnt", {16'b0, flush_cnt}, 32'h2);
    check("fs_pcf", pcf, 32'h84);

    // 6: PC wrap, counter saturation, reset mid-stall
    idle_inputs();
    BranchTakenE = 1; ALUResultE = 32'hFFFF_FFFC;
    step();
    check("wrap_pre_pcf", pcf, 32'hFFFF_FFFC);
    idle_inputs();
    step();
    check("wrap_pcf", pcf, 32'h0);
    check("wrap_instrd", instr_d, 32'h5A5A_FFFC);
    check("wrap_pc8d", pcplus8_d, 32'h4);
    StallF = 1; StallD = 1;
    for (int i = 0; i < 20; i++) step();
    check("sat_stallcnt4", {28'b0, stall_cnt4}, 32'hF);
    check("sat_stallcnt16", {16'b0, stall_cnt}, 32'd22);
    check("sat_flushcnt4", {28'b0, flush_cnt4}, 32'h2);
    reset = 1;
    #1;
    check("midrst_pcf", pcf, 32'h0);
    check("midrst_instrd", instr_d, 32'h0);
    check("midrst_pc8d", pcplus8_d, 32'h0);
    check("midrst_valid", {31'b0, valid_d}, 32'h0);
    check("midrst_stallcnt", {16'b0, stall_cnt}, 32'h0);
    check("midrst_flushcnt", {16'b0, flush_cnt}, 32'h0);
    check("midrst_stallcnt4", {28'b0, stall_cnt4}, 32'h0);
    step();
    check("held_rst_pcf", pcf, 32'h0);
    reset = 0;
    idle_inputs();
    step();
    check("post_rst_instrd", instr_d, KEY);
    check("post_rst_pcf", pcf, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
